// File: rtl/pcm_frame_buffer.sv
// Stereo sample FIFO between the tracker mixer and the DAC serializer.
// Stages one L/R pair per 32-bit DAC frame and counts frames that go out as silence.
module pcm_frame_buffer #(
  parameter  int DEPTH        = 16,
  parameter  int ALMOST_EMPTY = 4,
  localparam int AW           = $clog2(DEPTH),
  localparam int LW           = AW + 1
) (
  input  logic          bit_clock_in,
  input  logic          rst_active_low,
  input  logic [15:0]   sample_left,
  input  logic [15:0]   sample_right,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic [15:0]   pcm_data_left,
  output logic [15:0]   pcm_data_right,
  output logic          pcm_data_valid,
  output logic          frame_strobe,
  output logic [LW-1:0] fifo_level,
  output logic          almost_empty,
  output logic [15:0]   underrun_count,
  input  logic          underrun_clear
);

  logic [4:0]    frame_cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   mem [DEPTH];
  logic          consume;
  logic          fifo_nonempty;
  logic          push;
  logic          pop;
  logic [LW-1:0] level_next;

  // The serializer loads the staged pair on the edge where frame_cnt==31.
  assign consume       = (frame_cnt == 5'd31);
  assign fifo_nonempty = (fifo_level != '0);
  assign push          = sample_valid && sample_ready;
  // Pop on a frame edge, or prefetch mid-frame into an empty staging register.
  // Uses the pre-edge level, so a same-edge push into an empty FIFO is not seen.
  assign pop           = fifo_nonempty && (consume || !pcm_data_valid);

  always_comb begin
    level_next = fifo_level;
    if (push && !pop) begin
      level_next = fifo_level + LW'(1);
    end else if (pop && !push) begin
      level_next = fifo_level - LW'(1);
    end
  end

  always_ff @(posedge bit_clock_in) begin
    if (push) begin
      mem[wr_ptr] <= {sample_left, sample_right};
    end
  end

  always_ff @(posedge bit_clock_in or negedge rst_active_low) begin
    if (!rst_active_low) begin
      frame_cnt    <= '0;
      frame_strobe <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      sample_ready <= 1'b1;
      almost_empty <= 1'b1;
    end else begin
      frame_cnt    <= frame_cnt + 5'd1;
      frame_strobe <= (frame_cnt == 5'd30);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_level   <= level_next;
      sample_ready <= (level_next != LW'(DEPTH));
      almost_empty <= (level_next <= LW'(ALMOST_EMPTY));
    end
  end

  always_ff @(posedge bit_clock_in or negedge rst_active_low) begin
    if (!rst_active_low) begin
      pcm_data_left  <= '0;
      pcm_data_right <= '0;
      pcm_data_valid <= 1'b0;
    end else if (pop) begin
      {pcm_data_left, pcm_data_right} <= mem[rd_ptr];
      pcm_data_valid                  <= 1'b1;
    end else if (consume) begin
      pcm_data_left  <= '0;
      pcm_data_right <= '0;
      pcm_data_valid <= 1'b0;
    end
  end

  // A frame is silent when nothing valid was staged as the serializer loaded it.
  always_ff @(posedge bit_clock_in or negedge rst_active_low) begin
    if (!rst_active_low) begin
      underrun_count <= '0;
    end else if (underrun_clear) begin
      underrun_count <= '0;
    end else if (consume && !pcm_data_valid && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pcm_frame_buffer.sv
// Scoreboard bench for pcm_frame_buffer: accepted pairs are queued and
// compared against the staged pair at every serializer load edge.
module tb_pcm_frame_buffer;
  localparam int DEPTH = 16;

  logic        bit_clock_in = 1'b0;
  logic        rst_active_low = 1'b1;
  logic [15:0] sample_left = '0;
  logic [15:0] sample_right = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [15:0] pcm_data_left;
  logic [15:0] pcm_data_right;
  logic        pcm_data_valid;
  logic        frame_strobe;
  logic [4:0]  fifo_level;
  logic        almost_empty;
  logic [15:0] underrun_count;
  logic        underrun_clear = 1'b0;

  pcm_frame_buffer #(.DEPTH(DEPTH), .ALMOST_EMPTY(4)) dut (
    .bit_clock_in   (bit_clock_in),
    .rst_active_low (rst_active_low),
    .sample_left    (sample_left),
    .sample_right   (sample_right),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .pcm_data_left  (pcm_data_left),
    .pcm_data_right (pcm_data_right),
    .pcm_data_valid (pcm_data_valid),
    .frame_strobe   (frame_strobe),
    .fifo_level     (fifo_level),
    .almost_empty   (almost_empty),
    .underrun_count (underrun_count),
    .underrun_clear (underrun_clear)
  );

  always #5 bit_clock_in = ~bit_clock_in;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          edge_n;
  } pair_t;

  pair_t       sb[$];
  int          k = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] exp_under = '0;
  logic        acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
    end
  endtask

  // Called at a falling edge with k rising edges done since reset release.
  task automatic step(input logic v, input logic [15:0] l, input logic [15:0] r,
                      input logic clr, output logic accepted);
    logic exp_v;
    chk("frame_strobe", 32'(frame_strobe), 32'(k % 32 == 31));
    if (k % 32 == 0 && k > 0) chk("underrun_count", 32'(underrun_count), 32'(exp_under));
    if (k % 32 == 31) begin
      exp_v = (sb.size() > 0) && (sb[0].edge_n <= k - 1);
      chk("frame_valid", 32'(pcm_data_valid), 32'(exp_v));
      if (exp_v) begin
        chk("frame_data", {pcm_data_left, pcm_data_right}, {sb[0].l, sb[0].r});
        void'(sb.pop_front());
      end else if (exp_under != 16'hFFFF) begin
        exp_under = exp_under + 16'd1;
      end
    end
    if (clr) exp_under = '0;
    sample_valid   = v;
    sample_left    = l;
    sample_right   = r;
    underrun_clear = clr;
    accepted = v && sample_ready;
    if (accepted) sb.push_back('{l, r, k + 1});
    @(negedge bit_clock_in);
    k++;
    sample_valid   = 1'b0;
    underrun_clear = 1'b0;
  endtask

  task automatic idle_until(input int target);
    logic a;
    while (k < target) step(1'b0, 16'h0, 16'h0, 1'b0, a);
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 200 && !a; i++) step(1'b1, l, r, 1'b0, a);
    chk("push_accept", 32'(a), 32'd1);
  endtask

  task automatic apply_reset();
    #2;
    rst_active_low = 1'b0;
    sample_valid   = 1'b0;
    underrun_clear = 1'b0;
    #1;
    chk("rst_ready", 32'(sample_ready), 32'd1);
    chk("rst_valid", 32'(pcm_data_valid), 32'd0);
    chk("rst_data", {pcm_data_left, pcm_data_right}, 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
    chk("rst_strobe", 32'(frame_strobe), 32'd0);
    chk("rst_underrun", 32'(underrun_count), 32'd0);
    @(negedge bit_clock_in);
    rst_active_low = 1'b1;
    k = 0;
    sb.delete();
    exp_under = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Idle: every frame is silent.
    apply_reset();
    for (int i = 0; i < 96; i++) begin
      chk("idle_valid", 32'(pcm_data_valid), 32'd0);
      step(1'b0, 16'h0, 16'h0, 1'b0, acc);
    end
    chk("underrun_after_96", 32'(underrun_count), 32'd3);

    // Single pair: prefetched on the next edge and held to the frame edge.
    apply_reset();
    step(1'b0, 16'h0, 16'h0, 1'b0, acc);
    step(1'b1, 16'h1234, 16'hABCD, 1'b0, acc);
    chk("single_accept", 32'(acc), 32'd1);
    step(1'b0, 16'h0, 16'h0, 1'b0, acc);
    chk("single_staged_valid", 32'(pcm_data_valid), 32'd1);
    while (k < 31) begin
      chk("single_hold", {pcm_data_left, pcm_data_right}, 32'h1234ABCD);
      step(1'b0, 16'h0, 16'h0, 1'b0, acc);
    end
    idle_until(40);
    chk("single_no_underrun", 32'(underrun_count), 32'd0);

    // Back-to-back burst into a full FIFO.
    apply_reset();
    step(1'b1, 16'h2FFF, 16'hCFFF, 1'b0, acc);
    for (int i = 0; i < 20; i++) begin
      push_pair(16'h3000 + 16'(i), 16'hC000 + 16'(i));
      if (i == 15) begin
        chk("full_level", 32'(fifo_level), 32'd16);
        chk("full_ready", 32'(sample_ready), 32'd0);
        chk("full_almost_empty", 32'(almost_empty), 32'd0);
      end
      if (i == 16) chk("held_accept_edge", 32'(k), 32'd33);
    end
    idle_until(32 * 24);
    chk("burst_drained", 32'(sb.size()), 32'd0);

    // Eight pairs then silence; almost_empty rises at level 4.
    apply_reset();
    for (int i = 1; i <= 8; i++) push_pair(16'(i), 16'h0100 + 16'(i));
    chk("fill8_level", 32'(fifo_level), 32'd7);
    chk("fill8_almost_empty", 32'(almost_empty), 32'd0);
    idle_until(64);
    chk("level5", 32'(fifo_level), 32'd5);
    chk("level5_almost_empty", 32'(almost_empty), 32'd0);
    idle_until(96);
    chk("level4", 32'(fifo_level), 32'd4);
    chk("level4_almost_empty", 32'(almost_empty), 32'd1);
    idle_until(353);
    chk("fill8_underruns", 32'(underrun_count), 32'd3);

    // Push on the frame edge into an empty FIFO.
    apply_reset();
    idle_until(31);
    step(1'b1, 16'h5555, 16'hAAAA, 1'b0, acc);
    chk("edge_push_accept", 32'(acc), 32'd1);
    chk("edge_push_not_popped", 32'(pcm_data_valid), 32'd0);
    chk("edge_push_level", 32'(fifo_level), 32'd1);
    step(1'b0, 16'h0, 16'h0, 1'b0, acc);
    chk("edge_push_prefetch", 32'(pcm_data_valid), 32'd1);
    chk("edge_push_data", {pcm_data_left, pcm_data_right}, 32'h5555AAAA);
    idle_until(65);

    // Reset mid-frame with 5 buffered, then clear racing an underrun.
    apply_reset();
    for (int i = 0; i < 6; i++) push_pair(16'h6000 + 16'(i), 16'h9000 + 16'(i));
    idle_until(10);
    chk("pre_reset_level", 32'(fifo_level), 32'd5);
    apply_reset();
    idle_until(31);
    step(1'b0, 16'h0, 16'h0, 1'b1, acc);
    chk("clear_priority", 32'(underrun_count), 32'd0);
    idle_until(65);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
